// File: rtl/fixed_pkg.sv
// Shared definitions for the 8.8 fixed-point arithmetic blocks.
package fixed_pkg;

    localparam int unsigned FIX_W    = 16;
    localparam int unsigned FIX_FRAC = 8;
    localparam int unsigned QUOT_W   = 24;

    typedef logic [FIX_W-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fdiv_state_t;

    localparam fixed_t DIV_ZERO_RESULT = 16'hFFFF;

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module fixed_div_step
    import fixed_pkg::*;
(
    input  logic [QUOT_W:0]  rem_i,
    input  logic             dvd_bit_i,
    input  logic [FIX_W-1:0] divisor_i,
    output logic [QUOT_W:0]  rem_o,
    output logic             q_bit_o
);

    logic [QUOT_W:0] trial;
    logic [QUOT_W:0] divisor_ext;

    always_comb begin
        trial       = {rem_i[QUOT_W-1:0], dvd_bit_i};
        divisor_ext = {{(QUOT_W + 1 - FIX_W){1'b0}}, divisor_i};
        // A set bit shifted out of the remainder always exceeds any 16-bit divisor.
        q_bit_o     = rem_i[QUOT_W] | (trial >= divisor_ext);
        rem_o       = q_bit_o ? (trial - divisor_ext) : trial;
    end

endmodule

// File: rtl/fixed_divider.sv
// Sequential unsigned 8.8 restoring divider, one quotient bit per clock.
// Define FIXED_DIV_ROUND_EN for round-half-up (one guard iteration, one extra cycle).
module fixed_divider
    import fixed_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  fixed_t num1,
    input  fixed_t num2,
    output logic   busy,
    output logic   done,
    output fixed_t result,
    output logic   overflow,
    output logic   div_by_zero
);

`ifdef FIXED_DIV_ROUND_EN
    localparam int unsigned NumIter = QUOT_W + 1;
    localparam int unsigned PadW    = FIX_FRAC + 1;
`else
    localparam int unsigned NumIter = QUOT_W;
    localparam int unsigned PadW    = FIX_FRAC;
`endif
    localparam int unsigned CntW = $clog2(NumIter);

    fdiv_state_t          state_q, state_d;
    logic [NumIter-1:0]   dvd_q, dvd_d;
    logic [NumIter-2:0]   quot_q, quot_d;
    logic [QUOT_W:0]      rem_q, rem_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    fixed_t               divisor_q, divisor_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    fixed_t               result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 dbz_q, dbz_d;

    logic [QUOT_W:0]      step_rem;
    logic                 step_q_bit;
    logic [NumIter-1:0]   q_fin;
    fixed_t               fin_result;
    logic                 fin_overflow;

    fixed_div_step u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[NumIter-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

`ifdef FIXED_DIV_ROUND_EN
    logic [NumIter-1:0] q_rnd;

    always_comb begin
        q_fin        = {quot_q, step_q_bit};
        q_rnd        = {1'b0, q_fin[NumIter-1:1]} + NumIter'(q_fin[0]);
        fin_result   = q_rnd[FIX_W-1:0];
        // Bit 24 is the carry out of the rounding add.
        fin_overflow = |q_rnd[NumIter-1:FIX_W];
    end
`else
    always_comb begin
        q_fin        = {quot_q, step_q_bit};
        fin_result   = q_fin[FIX_W-1:0];
        fin_overflow = |q_fin[QUOT_W-1:FIX_W];
    end
`endif

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    divisor_d = num2;
                    busy_d    = 1'b1;
                    if (num2 != '0) begin
                        dvd_d   = {num1, {PadW{1'b0}}};
                        quot_d  = '0;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        result_d   = DIV_ZERO_RESULT;
                        overflow_d = 1'b1;
                        dbz_d      = 1'b1;
                    end
                end
            end
            RUN: begin
                dvd_d  = dvd_q << 1;
                rem_d  = step_rem;
                quot_d = {quot_q[NumIter-3:0], step_q_bit};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(NumIter - 1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    result_d   = fin_result;
                    overflow_d = fin_overflow;
                    dbz_d      = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            divisor_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Directed bench for fixed_divider with a result scoreboard and cycle-accurate latency checks.
module tb_fixed_divider;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
    } exp_t;

`ifdef FIXED_DIV_ROUND_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 25;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        div_by_zero;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    fixed_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num1        (num1),
        .num2        (num2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 16'h0000) begin
            e = '{res: 16'hFFFF, ovf: 1'b1, dbz: 1'b1};
        end else begin
`ifdef FIXED_DIV_ROUND_EN
            q = ({16'd0, a} << 9) / {16'd0, b};
            r = (q >> 1) + (q & 32'd1);
`else
            q = ({16'd0, a} << 8) / {16'd0, b};
            r = q;
`endif
            e = '{res: r[15:0], ovf: (r > 32'h0000_FFFF), dbz: 1'b0};
        end
        return e;
    endfunction

    // Drives start for one cycle (cycle 0); returns at the falling edge of cycle 1.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        num1  = a;
        num2  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes cycles 1..upto, pulsing start (with junk operands) in cycles plo..phi.
    task automatic watch(input string tag, input int exp_cyc, input int upto,
                         input int plo, input int phi);
        int   ndone = 0;
        int   dcyc  = -1;
        exp_t e     = '0;
        for (int c = 1; c <= upto; c++) begin
            if (c == 1) chk({tag, "_busy_c1"}, busy, 1);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = c;
                    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
                    if (sb.size() != 0) e = sb.pop_front();
                    chk({tag, "_result"}, result, e.res);
                    chk({tag, "_overflow"}, overflow, e.ovf);
                    chk({tag, "_dbz"}, div_by_zero, e.dbz);
                    chk({tag, "_busy_done"}, busy, 1);
                end
            end
            if (c == exp_cyc + 1) begin
                chk({tag, "_idle_busy"}, busy, 0);
                chk({tag, "_hold_result"}, result, e.res);
            end
            if (c >= plo && c <= phi) begin
                start = 1'b1;
                num1  = 16'hFFFF;
                num2  = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_done_cycle"}, dcyc, exp_cyc);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;

        rst   = 1'b1;
        start = 1'b0;
        num1  = '0;
        num2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        sb.push_back('{res: 16'h0080, ovf: 1'b0, dbz: 1'b0});
        issue(16'h0100, 16'h0200);
        watch("one_half", LAT, LAT + 1, 0, -1);

        sb.push_back('{res: 16'h0180, ovf: 1'b0, dbz: 1'b0});
        issue(16'h0300, 16'h0200);
        watch("start_ignored", LAT, 60, 5, 20);

        sb.push_back('{res: 16'h0000, ovf: 1'b1, dbz: 1'b0});
        issue(16'hFF00, 16'h0001);
        watch("overflow", LAT, LAT + 1, 0, -1);

        sb.push_back('{res: 16'hFFFF, ovf: 1'b1, dbz: 1'b1});
        issue(16'h1234, 16'h0000);
        watch("div_zero", 1, 2, 0, -1);

`ifdef FIXED_DIV_ROUND_EN
        sb.push_back('{res: 16'h00AB, ovf: 1'b0, dbz: 1'b0});
`else
        sb.push_back('{res: 16'h00AA, ovf: 1'b0, dbz: 1'b0});
`endif
        issue(16'h0200, 16'h0300);
        watch("two_thirds", LAT, LAT + 1, 0, -1);

        sb.push_back('{res: 16'h0100, ovf: 1'b0, dbz: 1'b0});
        issue(16'hFFFF, 16'hFFFF);
        watch("max_max", LAT, LAT + 1, 0, -1);

        sb.push_back(model(16'h0001, 16'hFFFF));
        issue(16'h0001, 16'hFFFF);
        watch("tiny", LAT, LAT + 1, 0, -1);

        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 16'hFFFF));
            sb.push_back(model(a, b));
            issue(a, b);
            watch("random", LAT, LAT + 1, 0, -1);
        end

        // Abort a division with reset in cycle 10, restart in cycle 12.
        issue(16'h0300, 16'h0200);
        for (int c = 1; c <= 10; c++) begin
            chk("abort_no_done", done, 0);
            if (c == 10) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_dbz", div_by_zero, 0);
        sb.push_back('{res: 16'h0140, ovf: 1'b0, dbz: 1'b0});
        issue(16'h0500, 16'h0400);
        watch("after_abort", LAT, LAT + 1, 0, -1);

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_divider.md
# fixed_divider

Sequential unsigned 8.8 fixed-point divider computing num1 / num2 by restoring division, one quotient bit per clock. It is the inverse operation to the fixed-point multiplier in the arithmetic library and shares its number format and overflow convention: result is the low 16 bits of the 24-bit quotient, and overflow is set when the upper 8 bits are non-zero. A start/busy/done handshake lets a controller issue one division at a time.

## Interface
- No parameters. Widths are fixed by the 8.8 format.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request; sampled only in IDLE
- num1  in  16  dividend, unsigned 8.8 (IIIIIIII.FFFFFFFF)
- num2  in  16  divisor, unsigned 8.8
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- result  out  16  quotient, unsigned 8.8
- overflow  out  1  quotient ≥ 256.0, or divide by zero
- div_by_zero  out  1  num2 was 0 for the current result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches num1/num2.
  - If num2≠0: load 24-bit dividend register with {num1, 8'h00}, clear 25-bit partial remainder and iteration counter; go to RUN.
  - If num2=0: go to DONE directly.
- RUN, one iteration per cycle, MSB first:
  - trial = {rem[23:0], dividend bit}.
  - If trial ≥ {8'h00, num2}: rem = trial − num2 and quotient bit = 1.
  - Otherwise: rem = trial and quotient bit = 0.
  - After the final iteration go to DONE.
- DONE: done=1 and outputs update. Next cycle is IDLE.
- Arithmetic: quotient q[23:0] = floor((num1·256)/num2).
  - result = q[15:0].
  - overflow = |q[23:16].
  - No saturation: result is the wrapped low bits.
- Divide by zero: result=16'hFFFF, overflow=1, div_by_zero=1.
- result, overflow and div_by_zero hold their values from DONE until the next DONE.
- start in RUN or DONE is ignored and not queued.
- Reset values: busy=0, done=0, result=16'h0000, overflow=0, div_by_zero=0, state IDLE.
- rst mid-operation aborts the division. Outputs return to their reset values and no done is issued.

## Timing
- start sampled high in cycle 0.
- Cycles 1–24: RUN, 24 iterations, busy=1.
- Cycle 25: DONE, done=1, busy=1, outputs valid.
- Cycle 26: IDLE. The earliest next start is sampled in cycle 26.
- Divide by zero: DONE in cycle 1, IDLE in cycle 2.
- With FIXED_DIV_ROUND_EN: RUN spans cycles 1–25, DONE is cycle 26, IDLE is cycle 27.
- Throughput: one division per 26 cycles (27 with rounding).

## Configuration
- FIXED_DIV_ROUND_EN defined:
  - Dividend becomes {num1, 9'h000}, giving 25 iterations and a guard bit q[0].
  - Rounded value r = q[24:1] + q[0] (round half up).
  - result = r[15:0]; overflow = |r[23:16] or carry out of r.
  - One extra cycle of latency.
- FIXED_DIV_ROUND_EN undefined: truncation, 24 iterations.

## Structure
- Shared package fixed_pkg:
  - FIX_W=16, FIX_FRAC=8, QUOT_W=24 constants.
  - fixed_t typedef (16-bit).
  - fdiv_state_t enum {IDLE, RUN, DONE}.
  - Divide-by-zero result constant 16'hFFFF.
- One combinational sub-module, fixed_div_step: compare-subtract.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
- Top level holds the FSM, iteration counter and registers.

## Test plan
- num1=0x0100, num2=0x0200 (1.0/2.0), start in cycle 0 → done in cycle 25, result=0x0080, overflow=0.
- num1=0x0300, num2=0x0200 → result=0x0180 (1.5), overflow=0. Pulse start high in cycles 5–20 during RUN → no effect, exactly one done.
- num1=0xFF00, num2=0x0001 → result=0x0000, overflow=1, div_by_zero=0.
- num2=0x0000 → done in cycle 1, result=0xFFFF, overflow=1, div_by_zero=1.
- num1=0x0200, num2=0x0300 (2/3) → 0x00AA without FIXED_DIV_ROUND_EN; 0x00AB with it, done in cycle 26.
- rst in cycle 10 of a division → no done, all outputs 0, busy=0. A new start in cycle 12 completes normally in cycle 37.
